// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU operation classes, datapath mux selects and trap causes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_REG    = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALU_OUT = 2'b00;
    localparam logic [1:0] RES_MDR     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // States that wait on mem_ready and are therefore guarded by the timeout.
    function automatic logic is_mem_state(state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for memory accesses; expired flags the last permitted
// waiting cycle so the FSM can trap instead of waiting again.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The increment out of this value would reach MEM_TIMEOUT.
    assign expired = (count == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, and traps on illegal opcodes or bus timeout.
module mc_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    state_t     state, next_state;
    logic [1:0] next_cause, cause_q;
    logic       in_mem, timer_expired, timed_out;

    assign in_mem    = is_mem_state(state);
    assign timed_out = in_mem && !mem_ready && timer_expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_mem || mem_ready),
        .enable  (in_mem && !mem_ready),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Cause is captured only on the transition into TRAP and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cause_q <= CAUSE_NONE;
        end else if (state != S_TRAP && next_state == S_TRAP) begin
            cause_q <= next_cause;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = CAUSE_NONE;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        result_src = RES_ALU_OUT;
        instr_done = 1'b0;

        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_RTYPE:          next_state = S_EXEC_R;
                    OP_ITYPE:          next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        next_state = S_TRAP;
                        next_cause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_IMM;
                next_state = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEM_WB;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                result_src = RES_MDR;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) begin
                    next_state = S_FETCH;
                end else if (timed_out) begin
                    next_state = S_TRAP;
                    next_cause = CAUSE_TIMEOUT;
                end
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_REG;
                alu_op     = ALU_FUNCT;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_FUNCT;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRC_A_REG;
                alu_op     = ALU_SUB;
                pc_write   = zero;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALU_WB;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_RESET;
        endcase
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control vectors.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       instr_done;
        logic       trap;
        logic [1:0] trap_cause;
    } ctrl_t;

    logic       clk, rst_n, zero, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, trap_cause;
    logic       instr_done, trap;

    ctrl_t act, exp_ctrl;
    bit    exp_valid;
    string step_name;
    int    tests, fails, cyc, done_at;

    mc_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .instr_done (instr_done),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, instr_done, trap, trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    // Per-cycle comparison against the model, plus the write-exclusivity rule.
    always @(negedge clk) begin
        if (exp_valid) begin
            tests++;
            if (act !== exp_ctrl) begin
                fails++;
                $display("[TB] FAIL %s: got %h expected %h", step_name, act, exp_ctrl);
            end
            tests++;
            if ($countones({ir_write, reg_write, mem_write}) > 1) begin
                fails++;
                $display("[TB] FAIL %s_exclusive: got %b%b%b required at most one", step_name,
                         ir_write, reg_write, mem_write);
            end
        end
    end

    function automatic ctrl_t mk(input logic mreq, input logic mwr, input logic adr,
                                 input logic irw, input logic pcw, input logic rw,
                                 input logic [1:0] a, input logic [1:0] b,
                                 input logic [1:0] op, input logic [1:0] rs, input logic done);
        ctrl_t c;
        c = '{mreq, mwr, adr, irw, pcw, rw, a, b, op, rs, done, 1'b0, 2'b00};
        return c;
    endfunction

    function automatic ctrl_t trap_exp(input logic [1:0] cause);
        ctrl_t c;
        c            = '0;
        c.trap       = 1'b1;
        c.trap_cause = cause;
        return c;
    endfunction

    function automatic ctrl_t fetch_exp(input logic ready);
        return mk(1, 0, 0, ready, ready, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0h required %0h", nm, got, want);
        end
    endtask

    // One clock of stimulus; called and returns at posedge+1.
    task automatic applyStimulus(input string nm, input ctrl_t e, input logic ready);
        mem_ready = ready;
        exp_ctrl  = e;
        step_name = nm;
        exp_valid = 1'b1;
        @(negedge clk);
        cyc++;
        if (instr_done === 1'b1 && done_at == 0) done_at = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        check({nm, "_async"}, 32'(act), 32'h0);
        @(posedge clk);
        #1;
        check({nm, "_held"}, 32'(act), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: expands one instruction into its cycles.
    task automatic checkOutput(input string nm, input logic [6:0] op, input logic z,
                               input int fetch_waits, input int mem_waits, input int want_len);
        cyc     = 0;
        done_at = 0;
        opcode  = op;
        zero    = z;
        for (int i = 0; i < fetch_waits; i++) applyStimulus({nm, "_fetch_wait"}, fetch_exp(0), 0);
        applyStimulus({nm, "_fetch"}, fetch_exp(1), 1);
        applyStimulus({nm, "_decode"}, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0), 1);
        case (op)
            7'b0110011: begin
                applyStimulus({nm, "_exec"}, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0), 1);
                applyStimulus({nm, "_wb"}, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1), 1);
            end
            7'b0010011: begin
                applyStimulus({nm, "_exec"}, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00, 0), 1);
                applyStimulus({nm, "_wb"}, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1), 1);
            end
            7'b0000011: begin
                applyStimulus({nm, "_adr"}, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 1);
                for (int i = 0; i < mem_waits; i++)
                    applyStimulus({nm, "_rd_wait"}, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
                applyStimulus({nm, "_rd"}, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
                applyStimulus({nm, "_wb"}, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1), 1);
            end
            7'b0100011: begin
                applyStimulus({nm, "_adr"}, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0), 1);
                for (int i = 0; i < mem_waits; i++)
                    applyStimulus({nm, "_wr_wait"}, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
                applyStimulus({nm, "_wr"}, mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1), 1);
            end
            7'b1100011: begin
                applyStimulus({nm, "_beq"}, mk(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1), 1);
            end
            7'b1101111: begin
                applyStimulus({nm, "_jal"}, mk(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'b00, 0), 1);
                applyStimulus({nm, "_wb"}, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1), 1);
            end
            default: ;
        endcase
        check({nm, "_latency"}, 32'(done_at), 32'(want_len));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        exp_valid = 1'b0;
        rst_n     = 1'b0;
        opcode    = 7'b0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset("por");

        checkOutput("add",   7'b0110011, 0, 0, 0, 4);
        checkOutput("addi",  7'b0010011, 0, 0, 0, 4);
        checkOutput("lw_w3", 7'b0000011, 0, 0, 3, 8);
        checkOutput("sw",    7'b0100011, 0, 0, 0, 4);
        checkOutput("sw_w2", 7'b0100011, 0, 0, 2, 6);
        checkOutput("beq_t", 7'b1100011, 1, 0, 0, 3);
        checkOutput("beq_n", 7'b1100011, 0, 0, 0, 3);
        checkOutput("jal",   7'b1101111, 0, 0, 0, 4);
        checkOutput("add_fw15", 7'b0110011, 0, 15, 0, 19);
        checkOutput("lw_w15",   7'b0000011, 0, 0, 15, 20);

        // Reset dropped between edges while in EXEC_R.
        opcode = 7'b0110011;
        cyc    = 0;
        applyStimulus("rst_mid_fetch", fetch_exp(1), 1);
        applyStimulus("rst_mid_decode", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0), 1);
        exp_valid = 1'b0;
        #2;
        check("rst_mid_exec_aluop", 32'(alu_op), 32'h2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs_zero", 32'(act), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("add_after_rst", 7'b0110011, 0, 0, 0, 4);

        // Illegal opcode traps after DECODE and sits there until reset.
        opcode = 7'b1111111;
        applyStimulus("ill_fetch", fetch_exp(1), 1);
        applyStimulus("ill_decode", mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, 0), 1);
        for (int i = 0; i < 20; i++) applyStimulus("ill_trap", trap_exp(2'b01), i[0]);
        exp_valid = 1'b0;
        check("ill_trap_literal", 32'({trap, trap_cause}), 32'h5);
        do_reset("ill_reset");
        checkOutput("add_after_trap", 7'b0110011, 0, 0, 0, 4);

        // Fetch never completes: the 16th waiting cycle is the last.
        opcode = 7'b0110011;
        for (int i = 0; i < 16; i++) applyStimulus("to_fetch_wait", fetch_exp(0), 0);
        for (int i = 0; i < 3; i++) applyStimulus("to_trap", trap_exp(2'b10), 0);
        exp_valid = 1'b0;
        check("to_trap_literal", 32'({trap, trap_cause}), 32'h6);
        do_reset("to_reset");

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
